// File: rtl/reduce_tree_pipe_pkg.sv
// Shared constants and helpers for the pipelined bitwise reduction unit.
package reduce_pkg;

  localparam logic [1:0] MODE_OR   = 2'b00;
  localparam logic [1:0] MODE_AND  = 2'b01;
  localparam logic [1:0] MODE_XOR  = 2'b10;
  localparam logic [1:0] MODE_XNOR = 2'b11;

  // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if (int'(32'd1 << i) < n) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Pad bit that leaves the reduction result unchanged for the given op.
  function automatic logic ident(input logic [1:0] mode);
    logic pad;
    case (mode)
      MODE_AND: pad = 1'b1;
      MODE_OR:  pad = 1'b0;
      MODE_XOR: pad = 1'b0;
      default:  pad = 1'b0;
    endcase
    return pad;
  endfunction

endpackage

// File: rtl/reduce_tree_pipe_if.sv
// Operand/result handshake bundle for the reduction unit.
interface reduce_tree_pipe_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic [1:0]   mode;
  logic         out_valid;
  logic         out_ready;
  logic         out_bit;
  logic [1:0]   out_mode;

  // Producer/consumer side, i.e. whoever feeds operands and takes results.
  modport master (
    output in_valid, x, mode, out_ready,
    input  in_ready, out_valid, out_bit, out_mode
  );

  // The reduction unit itself.
  modport slave (
    input  in_valid, x, mode, out_ready,
    output in_ready, out_valid, out_bit, out_mode
  );
endinterface

// File: rtl/reduce_tree_pipe_stage.sv
// One pipeline slice of the reduction tree: LEVELS tree levels of
// combinational reduction followed by an enabled data/mode/valid register.
module reduce_stage
  import reduce_pkg::*;
#(
  parameter int IN_W   = 2,
  parameter int LEVELS = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [IN_W-1:0]             in_data,
  input  logic [1:0]                  in_mode,
  input  logic                        in_valid,
  output logic [(IN_W>>LEVELS)-1:0]   out_data,
  output logic [1:0]                  out_mode,
  output logic                        out_valid
);

  // Each output bit is the reduction of a contiguous group of 2^LEVELS inputs,
  // i.e. LEVELS levels of a balanced binary tree.
  localparam int GRP   = 1 << LEVELS;
  localparam int OUT_W = IN_W >> LEVELS;

  logic [OUT_W-1:0] red_s;
  logic [GRP-1:0]   chunk_s;
  logic [OUT_W-1:0] data_r;
  logic [1:0]       mode_r;
  logic             valid_r;

  // Reduce each group under the op; XNOR runs as XOR and is inverted at the end.
  always_comb begin
    red_s   = {OUT_W{1'b0}};
    chunk_s = {GRP{1'b0}};
    for (int j = 0; j < OUT_W; j++) begin
      chunk_s = in_data[j*GRP +: GRP];
      case (in_mode)
        MODE_OR:   red_s[j] = |chunk_s;
        MODE_AND:  red_s[j] = &chunk_s;
        MODE_XOR:  red_s[j] = ^chunk_s;
        MODE_XNOR: red_s[j] = ^chunk_s;
        default:   red_s[j] = 1'b0;
      endcase
    end
  end

  // Stage register: loads on the global advance, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r  <= {OUT_W{1'b0}};
      mode_r  <= 2'b00;
      valid_r <= 1'b0;
    end else if (en) begin
      data_r  <= red_s;
      mode_r  <= in_mode;
      valid_r <= in_valid;
    end else begin
      data_r  <= data_r;
      mode_r  <= mode_r;
      valid_r <= valid_r;
    end
  end

  assign out_data  = data_r;
  assign out_mode  = mode_r;
  assign out_valid = valid_r;

endmodule

// File: rtl/reduce_tree_pipe.sv
// Pipelined W-bit to 1-bit reduction (OR/AND/XOR/XNOR) with valid/ready on
// both sides and a single global stall. Feeds the ALU zero/all-ones/parity flags.
module reduce_tree_pipe
  import reduce_pkg::*;
#(
  parameter int W   = 16,
  parameter int LPS = 1
) (
  input logic              clk,
  input logic              rst_n,
  reduce_tree_pipe_if.slave bus
);

  localparam int L = clog2(W);
  localparam int P = 1 << L;
  localparam int S = (L + LPS - 1) / LPS;

  logic         advance_s;
  logic [P-1:0] x_pad_s;
  logic         last_data_s;
  logic [1:0]   last_mode_s;
  logic         last_valid_s;

  // The whole pipe moves together unless a held result is still waiting.
  assign advance_s    = !last_valid_s | bus.out_ready;
  assign bus.in_ready = advance_s;

  // Fill leaves above W with the op identity so they never change the result.
  always_comb begin
    x_pad_s        = {P{ident(bus.mode)}};
    x_pad_s[W-1:0] = bus.x;
  end

  for (genvar s = 0; s < S; s++) begin : g_stage
    localparam int IN_W  = P >> (s * LPS);
    localparam int LEV   = ((L - s * LPS) < LPS) ? (L - s * LPS) : LPS;
    localparam int OUT_W = IN_W >> LEV;

    logic [IN_W-1:0]  din_s;
    logic [1:0]       mode_in_s;
    logic             vin_s;
    logic [OUT_W-1:0] dout_s;
    logic [1:0]       mode_out_s;
    logic             vout_s;

    if (s == 0) begin : g_first
      assign din_s     = x_pad_s;
      assign mode_in_s = bus.mode;
      assign vin_s     = bus.in_valid;
    end else begin : g_next
      assign din_s     = g_stage[s-1].dout_s;
      assign mode_in_s = g_stage[s-1].mode_out_s;
      assign vin_s     = g_stage[s-1].vout_s;
    end

    reduce_stage #(
      .IN_W   (IN_W),
      .LEVELS (LEV)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (advance_s),
      .in_data   (din_s),
      .in_mode   (mode_in_s),
      .in_valid  (vin_s),
      .out_data  (dout_s),
      .out_mode  (mode_out_s),
      .out_valid (vout_s)
    );
  end

  assign last_data_s  = g_stage[S-1].dout_s;
  assign last_mode_s  = g_stage[S-1].mode_out_s;
  assign last_valid_s = g_stage[S-1].vout_s;

  // XNOR results leave the tree as XOR parity; flip them on the way out.
  assign bus.out_bit   = last_data_s ^ (last_mode_s == MODE_XNOR);
  assign bus.out_mode  = last_mode_s;
  assign bus.out_valid = last_valid_s;

endmodule

// File: tb/tb_reduce_tree_pipe.sv
// Self-checking bench: W=16/LPS=1 and W=12/LPS=2 instances, directed cases,
// backpressure, mid-run reset and a random soak against a ones-count model.
module tb_reduce_tree_pipe;

  localparam int S16 = 4;
  localparam int S12 = 2;

  typedef struct {
    logic       b;
    logic [1:0] m;
    int         acc;
    int         stl;
  } item_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reduce_tree_pipe_if #(.W(16)) bus16 ();
  reduce_tree_pipe_if #(.W(12)) bus12 ();

  reduce_tree_pipe #(.W(16), .LPS(1)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  reduce_tree_pipe #(.W(12), .LPS(2)) dut12 (.clk(clk), .rst_n(rst_n), .bus(bus12));

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  item_t q0[$];
  item_t q1[$];
  logic       pv[2] = '{1'b0, 1'b0};
  logic       px[2] = '{1'b0, 1'b0};
  logic       ps[2] = '{1'b0, 1'b0};
  logic       pb[2] = '{1'b0, 1'b0};
  logic [1:0] pm[2] = '{2'b00, 2'b00};
  int         stl[2] = '{0, 0};
  int         acc_cnt[2] = '{0, 0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: count ones over the real operand width, then apply the op rule.
  function automatic logic ref_red(input logic [15:0] xv, input int w, input logic [1:0] m);
    int ones;
    ones = 0;
    for (int i = 0; i < w; i++) ones += int'(xv[i]);
    case (m)
      2'b00:   return ones > 0;
      2'b01:   return ones == w;
      2'b10:   return (ones % 2) == 1;
      default: return (ones % 2) == 0;
    endcase
  endfunction

  task automatic mon(input int id, input logic iv, input logic ir, input logic [15:0] xv,
                     input logic [1:0] m, input logic ov, input logic orr, input logic ob,
                     input logic [1:0] om);
    item_t it;
    int sdep;
    int w;
    int qn;
    sdep = (id == 0) ? S16 : S12;
    w    = (id == 0) ? 16 : 12;
    if (!rst_n) begin
      if (id == 0) q0.delete(); else q1.delete();
      pv[id] = 1'b0; px[id] = 1'b0; ps[id] = 1'b0;
      return;
    end
    check("in_ready", ir, !ov | orr);
    if (ps[id]) begin
      check("hold_valid", ov, 1);
      check("hold_bit", ob, pb[id]);
      check("hold_mode", om, pm[id]);
    end
    qn = (id == 0) ? q0.size() : q1.size();
    if (ov && (!pv[id] || px[id])) begin
      if (qn == 0) check("spurious_out", ov, 0);
      else begin
        it = (id == 0) ? q0[0] : q1[0];
        check("latency", cyc - it.acc, sdep + stl[id] - it.stl);
      end
    end
    if (ov && orr) begin
      if (qn == 0) check("extra_out", ov, 0);
      else begin
        if (id == 0) it = q0.pop_front(); else it = q1.pop_front();
        check("out_bit", ob, it.b);
        check("out_mode", om, it.m);
      end
    end
    if (iv && ir) begin
      it.b = ref_red(xv, w, m); it.m = m; it.acc = cyc; it.stl = stl[id];
      if (id == 0) q0.push_back(it); else q1.push_back(it);
      acc_cnt[id]++;
    end
    pv[id] = ov; px[id] = ov && orr; ps[id] = ov && !orr;
    pb[id] = ob; pm[id] = om;
    if (ov && !orr) stl[id]++;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    mon(0, bus16.in_valid, bus16.in_ready, bus16.x, bus16.mode,
        bus16.out_valid, bus16.out_ready, bus16.out_bit, bus16.out_mode);
    mon(1, bus12.in_valid, bus12.in_ready, {4'h0, bus12.x}, bus12.mode,
        bus12.out_valid, bus12.out_ready, bus12.out_bit, bus12.out_mode);
  end

  task automatic set_in(input int id, input logic v, input logic [15:0] xv, input logic [1:0] m);
    if (id == 0) begin
      bus16.in_valid = v; bus16.x = xv; bus16.mode = m;
    end else begin
      bus12.in_valid = v; bus12.x = xv[11:0]; bus12.mode = m;
    end
  endtask

  task automatic put(input int id, input logic [15:0] xv, input logic [1:0] m);
    logic got;
    int n;
    set_in(id, 1'b1, xv, m);
    got = 1'b0;
    n = 0;
    while (!got && n < 50) begin
      @(negedge clk);
      got = (id == 0) ? bus16.in_ready : bus12.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!got) check("put_timeout", got, 1);
  endtask

  task automatic idle(input int n);
    set_in(0, 1'b0, 16'h0000, 2'b00);
    set_in(1, 1'b0, 16'h0000, 2'b00);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [15:0] bp_x[6] = '{16'h000E, 16'hFFFF, 16'h0007, 16'h0000, 16'h8001, 16'h1234};
  logic [1:0]  bp_m[6] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b11, 2'b10};

  initial begin
    int idx;
    logic saw_block;
    int target;
    int budget;

    set_in(0, 1'b0, 16'h0000, 2'b00);
    set_in(1, 1'b0, 16'h0000, 2'b00);
    bus16.out_ready = 1'b1;
    bus12.out_ready = 1'b1;

    // Reset state
    #2;
    check("rst_out_valid16", bus16.out_valid, 0);
    check("rst_out_bit16", bus16.out_bit, 0);
    check("rst_out_mode16", bus16.out_mode, 0);
    check("rst_in_ready16", bus16.in_ready, 1);
    check("rst_out_valid12", bus12.out_valid, 0);
    check("rst_in_ready12", bus12.in_ready, 1);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    // OR
    put(0, 16'h000E, 2'b00);
    put(0, 16'h0000, 2'b00);
    idle(8);

    // AND/XOR/XNOR back-to-back
    put(0, 16'hFFFF, 2'b01);
    put(0, 16'hFFFE, 2'b01);
    put(0, 16'h0007, 2'b10);
    put(0, 16'h0007, 2'b11);
    idle(8);

    // Backpressure: 6 items, out_ready low for cycles 4..8
    idx = 0;
    saw_block = 1'b0;
    for (int c = 0; c < 24; c++) begin
      if (idx < 6) set_in(0, 1'b1, bp_x[idx], bp_m[idx]);
      else set_in(0, 1'b0, 16'h0000, 2'b00);
      bus16.out_ready = !(c >= 4 && c < 9);
      @(negedge clk);
      if (bus16.in_valid && bus16.in_ready) idx++;
      if (bus16.out_valid && !bus16.in_ready) saw_block = 1'b1;
      @(posedge clk); #1;
    end
    check("bp_in_ready_drop", saw_block, 1);
    check("bp_accepted", idx, 6);
    check("bp_drained", q0.size(), 0);
    bus16.out_ready = 1'b1;
    idle(2);

    // Reset mid-run with a full pipeline
    put(0, 16'hA5A5, 2'b10);
    put(0, 16'hFFFF, 2'b01);
    put(0, 16'h0100, 2'b00);
    put(0, 16'h0003, 2'b11);
    #1;
    rst_n = 1'b0;
    set_in(0, 1'b0, 16'h0000, 2'b00);
    #1;
    check("midrst_out_valid", bus16.out_valid, 0);
    check("midrst_in_ready", bus16.in_ready, 1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("post_rst_quiet", bus16.out_valid, 0);
    end
    @(posedge clk); #1;
    put(0, 16'h0040, 2'b00);
    idle(8);

    // Non-power-of-two width, two tree levels per stage
    put(1, 16'h0FFF, 2'b01);
    put(1, 16'h0800, 2'b00);
    put(1, 16'h0801, 2'b10);
    put(1, 16'h0FFE, 2'b01);
    put(1, 16'h0801, 2'b11);
    idle(6);
    check("w12_drained", q1.size(), 0);

    // Random soak
    target = acc_cnt[0] + 10000;
    budget = 0;
    while (acc_cnt[0] < target && budget < 60000) begin
      set_in(0, ($urandom_range(3) != 0), 16'($urandom), 2'($urandom_range(3)));
      bus16.out_ready = ($urandom_range(3) != 0);
      @(posedge clk); #1;
      budget++;
    end
    check("soak_items", acc_cnt[0] - (target - 10000), 10000);
    bus16.out_ready = 1'b1;
    idle(10);
    check("drain16", q0.size(), 0);
    check("drain12", q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
